// File: rtl/rvfi_commit_packer.sv
// Compacts up to COMMIT_WIDTH retiring ROB slots onto the low RVFI channels in program order, stamps order numbers, latches halt.
// Latency 1 cycle, all outputs registered; no backpressure, every eligible slot is emitted.
module rvfi_commit_packer #(
  parameter int COMMIT_WIDTH = 4,
  parameter int ORDER_W      = 64,
  parameter int NCH          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COMMIT_WIDTH-1:0]              ret_valid,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_inst,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_pc_rdata,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_pc_wdata,
  input  logic [COMMIT_WIDTH-1:0][4:0]         ret_rs1_addr,
  input  logic [COMMIT_WIDTH-1:0][4:0]         ret_rs2_addr,
  input  logic [COMMIT_WIDTH-1:0][4:0]         ret_rd_addr,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_rs1_rdata,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_rs2_rdata,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_rd_wdata,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_mem_addr,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_mem_rdata,
  input  logic [COMMIT_WIDTH-1:0][31:0]        ret_mem_wdata,
  input  logic [COMMIT_WIDTH-1:0][3:0]         ret_mem_rmask,
  input  logic [COMMIT_WIDTH-1:0][3:0]         ret_mem_wmask,
  output logic [NCH-1:0]                       rvfi_valid,
  output logic [NCH-1:0][ORDER_W-1:0]          rvfi_order,
  output logic [NCH-1:0][31:0]                 rvfi_inst,
  output logic [NCH-1:0][31:0]                 rvfi_pc_rdata,
  output logic [NCH-1:0][31:0]                 rvfi_pc_wdata,
  output logic [NCH-1:0][4:0]                  rvfi_rs1_addr,
  output logic [NCH-1:0][4:0]                  rvfi_rs2_addr,
  output logic [NCH-1:0][4:0]                  rvfi_rd_addr,
  output logic [NCH-1:0][31:0]                 rvfi_rs1_rdata,
  output logic [NCH-1:0][31:0]                 rvfi_rs2_rdata,
  output logic [NCH-1:0][31:0]                 rvfi_rd_wdata,
  output logic [NCH-1:0][31:0]                 rvfi_mem_addr,
  output logic [NCH-1:0][3:0]                  rvfi_mem_rmask,
  output logic [NCH-1:0][3:0]                  rvfi_mem_wmask,
  output logic [NCH-1:0][31:0]                 rvfi_mem_rdata,
  output logic [NCH-1:0][31:0]                 rvfi_mem_wdata,
  output logic                                 halted,
  output logic [ORDER_W-1:0]                   retired_count
);

  localparam int CW = $clog2(NCH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } chan_t;

  chan_t [NCH-1:0]              chan_d, chan_q;
  logic  [NCH-1:0]              valid_d, valid_q;
  logic  [NCH-1:0][ORDER_W-1:0] order_d, order_q;
  logic  [ORDER_W-1:0]          base_d, base_q;
  logic                         halted_d, halted_q;

  always_comb begin
    logic          blocked;
    logic          hc;
    logic [CW:0]   cnt;
    chan_t         c;
    chan_d   = '0;
    valid_d  = '0;
    order_d  = '0;
    blocked  = 1'b0;
    hc       = 1'b0;
    cnt      = '0;
    c        = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      hc = (ret_pc_rdata[i] == ret_pc_wdata[i]) || (ret_inst[i] == 32'h0000_0063) ||
           (ret_inst[i] == 32'h0000_006F) || (ret_inst[i] == 32'hF000_2013);
      if (ret_valid[i] && !halted_q && !blocked) begin
        c.inst      = ret_inst[i];
        c.pc_rdata  = ret_pc_rdata[i];
        c.pc_wdata  = ret_pc_wdata[i];
        c.rs1_addr  = ret_rs1_addr[i];
        c.rs2_addr  = ret_rs2_addr[i];
        c.rd_addr   = ret_rd_addr[i];
        // x0 reads and writes are architecturally zero regardless of what the ROB carries
        c.rs1_rdata = (ret_rs1_addr[i] == 5'd0) ? 32'd0 : ret_rs1_rdata[i];
        c.rs2_rdata = (ret_rs2_addr[i] == 5'd0) ? 32'd0 : ret_rs2_rdata[i];
        c.rd_wdata  = (ret_rd_addr[i] == 5'd0) ? 32'd0 : ret_rd_wdata[i];
        c.mem_addr  = ret_mem_addr[i];
        c.mem_rmask = ret_mem_rmask[i];
        c.mem_wmask = ret_mem_wmask[i];
        c.mem_rdata = ret_mem_rdata[i];
        c.mem_wdata = ret_mem_wdata[i];
        chan_d[cnt[CW-1:0]]  = c;
        valid_d[cnt[CW-1:0]] = 1'b1;
        order_d[cnt[CW-1:0]] = base_q + ORDER_W'(cnt);
        cnt = cnt + 1'b1;
        if (hc) blocked = 1'b1;
      end
    end
    base_d   = base_q + ORDER_W'(cnt);
    halted_d = halted_q | blocked;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      chan_q   <= '0;
      valid_q  <= '0;
      order_q  <= '0;
      base_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      chan_q   <= chan_d;
      valid_q  <= valid_d;
      order_q  <= order_d;
      base_q   <= base_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NCH; r++) begin
      rvfi_inst[r]      = chan_q[r].inst;
      rvfi_pc_rdata[r]  = chan_q[r].pc_rdata;
      rvfi_pc_wdata[r]  = chan_q[r].pc_wdata;
      rvfi_rs1_addr[r]  = chan_q[r].rs1_addr;
      rvfi_rs2_addr[r]  = chan_q[r].rs2_addr;
      rvfi_rd_addr[r]   = chan_q[r].rd_addr;
      rvfi_rs1_rdata[r] = chan_q[r].rs1_rdata;
      rvfi_rs2_rdata[r] = chan_q[r].rs2_rdata;
      rvfi_rd_wdata[r]  = chan_q[r].rd_wdata;
      rvfi_mem_addr[r]  = chan_q[r].mem_addr;
      rvfi_mem_rmask[r] = chan_q[r].mem_rmask;
      rvfi_mem_wmask[r] = chan_q[r].mem_wmask;
      rvfi_mem_rdata[r] = chan_q[r].mem_rdata;
      rvfi_mem_wdata[r] = chan_q[r].mem_wdata;
    end
  end

  assign rvfi_valid    = valid_q;
  assign rvfi_order    = order_q;
  assign halted        = halted_q;
  assign retired_count = base_q;

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Scoreboard bench for rvfi_commit_packer: randomized retire groups against a queue-based reference model.
module tb_rvfi_commit_packer;

  localparam int CWID = 4;
  localparam int OW   = 8;
  localparam int NC   = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } ch_t;

  typedef struct packed {
    logic [NC-1:0]         v;
    logic [NC-1:0][OW-1:0] ord;
    ch_t  [NC-1:0]         ch;
    logic                  h;
    logic [OW-1:0]         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CWID-1:0]       t_valid = '0;
  logic [CWID-1:0][31:0] t_inst = '0, t_pcr = '0, t_pcw = '0;
  logic [CWID-1:0][4:0]  t_rs1a = '0, t_rs2a = '0, t_rda = '0;
  logic [CWID-1:0][31:0] t_rs1d = '0, t_rs2d = '0, t_rdd = '0;
  logic [CWID-1:0][31:0] t_maddr = '0, t_mrd = '0, t_mwd = '0;
  logic [CWID-1:0][3:0]  t_rmask = '0, t_wmask = '0;

  logic [NC-1:0]         o_valid;
  logic [NC-1:0][OW-1:0] o_order;
  logic [NC-1:0][31:0]   o_inst, o_pcr, o_pcw, o_rs1d, o_rs2d, o_rdd, o_maddr, o_mrd, o_mwd;
  logic [NC-1:0][4:0]    o_rs1a, o_rs2a, o_rda;
  logic [NC-1:0][3:0]    o_rmask, o_wmask;
  logic                  o_halted;
  logic [OW-1:0]         o_count;

  rvfi_commit_packer #(.COMMIT_WIDTH(CWID), .ORDER_W(OW), .NCH(NC)) dut (
    .clk(clk), .rst(rst), .ret_valid(t_valid), .ret_inst(t_inst),
    .ret_pc_rdata(t_pcr), .ret_pc_wdata(t_pcw),
    .ret_rs1_addr(t_rs1a), .ret_rs2_addr(t_rs2a), .ret_rd_addr(t_rda),
    .ret_rs1_rdata(t_rs1d), .ret_rs2_rdata(t_rs2d), .ret_rd_wdata(t_rdd),
    .ret_mem_addr(t_maddr), .ret_mem_rdata(t_mrd), .ret_mem_wdata(t_mwd),
    .ret_mem_rmask(t_rmask), .ret_mem_wmask(t_wmask),
    .rvfi_valid(o_valid), .rvfi_order(o_order), .rvfi_inst(o_inst),
    .rvfi_pc_rdata(o_pcr), .rvfi_pc_wdata(o_pcw),
    .rvfi_rs1_addr(o_rs1a), .rvfi_rs2_addr(o_rs2a), .rvfi_rd_addr(o_rda),
    .rvfi_rs1_rdata(o_rs1d), .rvfi_rs2_rdata(o_rs2d), .rvfi_rd_wdata(o_rdd),
    .rvfi_mem_addr(o_maddr), .rvfi_mem_rmask(o_rmask), .rvfi_mem_wmask(o_wmask),
    .rvfi_mem_rdata(o_mrd), .rvfi_mem_wdata(o_mwd),
    .halted(o_halted), .retired_count(o_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];
  logic [OW-1:0] m_base = '0;
  bit            m_halt = 1'b0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_halt(input logic [31:0] pcr, input logic [31:0] pcw, input logic [31:0] inst);
    return (pcr == pcw) || (inst == 32'h63) || (inst == 32'h6F) || (inst == 32'hF0002013);
  endfunction

  // Randomize all slot payloads for the next cycle; callers may override fields before commit().
  task automatic rand_slots(input logic [CWID-1:0] vm);
    @(negedge clk);
    t_valid = vm;
    for (int i = 0; i < CWID; i++) begin
      t_inst[i]  = $urandom | 32'h0000_0100;
      t_pcr[i]   = $urandom & 32'hFFFF_FFFC;
      t_pcw[i]   = t_pcr[i] + 32'd4;
      t_rs1a[i]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t_rs2a[i]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t_rda[i]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t_rs1d[i]  = $urandom;
      t_rs2d[i]  = $urandom;
      t_rdd[i]   = $urandom;
      t_maddr[i] = $urandom;
      t_mrd[i]   = $urandom;
      t_mwd[i]   = $urandom;
      t_rmask[i] = 4'($urandom);
      t_wmask[i] = 4'($urandom);
    end
  endtask

  task automatic make_halt(input int slot, input int kind);
    case (kind)
      0: t_pcw[slot] = t_pcr[slot];
      1: t_inst[slot] = 32'h0000_0063;
      2: t_inst[slot] = 32'h0000_006F;
      default: t_inst[slot] = 32'hF000_2013;
    endcase
  endtask

  // Reference: collect valid slots oldest-first, stop after the first halt-class one.
  task automatic commit(input logic rst_v);
    exp_t e;
    int   sel[$];
    ch_t  c;
    rst = rst_v;
    e = '0;
    if (!rst_v) begin
      m_base = '0;
      m_halt = 1'b0;
    end else begin
      if (!m_halt) begin
        for (int i = 0; i < CWID; i++) begin
          if (t_valid[i]) begin
            sel.push_back(i);
            if (is_halt(t_pcr[i], t_pcw[i], t_inst[i])) begin
              m_halt = 1'b1;
              break;
            end
          end
        end
      end
      foreach (sel[r]) begin
        int s = sel[r];
        c.inst = t_inst[s];          c.pc_rdata = t_pcr[s];        c.pc_wdata = t_pcw[s];
        c.rs1_addr = t_rs1a[s];      c.rs2_addr = t_rs2a[s];       c.rd_addr = t_rda[s];
        c.rs1_rdata = (t_rs1a[s] == 0) ? 32'd0 : t_rs1d[s];
        c.rs2_rdata = (t_rs2a[s] == 0) ? 32'd0 : t_rs2d[s];
        c.rd_wdata  = (t_rda[s] == 0) ? 32'd0 : t_rdd[s];
        c.mem_addr = t_maddr[s];     c.mem_rmask = t_rmask[s];     c.mem_wmask = t_wmask[s];
        c.mem_rdata = t_mrd[s];      c.mem_wdata = t_mwd[s];
        e.ch[r]  = c;
        e.v[r]   = 1'b1;
        e.ord[r] = m_base + OW'(r);
      end
      m_base = m_base + OW'(sel.size());
    end
    e.h   = m_halt;
    e.cnt = m_base;
    expq.push_back(e);
  endtask

  task automatic cyc(input logic rst_v, input logic [CWID-1:0] vm);
    rand_slots(vm);
    commit(rst_v);
  endtask

  initial begin : monitor
    exp_t e;
    ch_t  a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rvfi_valid", 384'(o_valid), 384'(e.v));
        check("halted", 384'(o_halted), 384'(e.h));
        check("retired_count", 384'(o_count), 384'(e.cnt));
        for (int c = 0; c < NC; c++) begin
          a = {o_inst[c], o_pcr[c], o_pcw[c], o_rs1a[c], o_rs2a[c], o_rda[c], o_rs1d[c], o_rs2d[c],
               o_rdd[c], o_maddr[c], o_rmask[c], o_wmask[c], o_mrd[c], o_mwd[c]};
          check($sformatf("ch%0d_payload", c), 384'(a), 384'(e.ch[c]));
          check($sformatf("ch%0d_order", c), 384'(o_order[c]), 384'(e.ord[c]));
        end
      end
    end
  end

  initial begin : stim
    cyc(1'b0, 4'hF);
    cyc(1'b0, 4'hF);
    // basic compaction: slots 1 and 3 only
    rand_slots(4'b1010);
    t_pcr[1] = 32'h100; t_pcw[1] = 32'h104;
    t_pcr[3] = 32'h104; t_pcw[3] = 32'h108;
    commit(1'b1);
    cyc(1'b1, 4'b0000);
    cyc(1'b0, 4'b0000);
    repeat (3) cyc(1'b1, 4'b1111);
    // scrub of x0 operands
    rand_slots(4'b0100);
    t_rda[2] = 5'd0; t_rdd[2] = 32'hDEADBEEF; t_rs1a[2] = 5'd0;
    commit(1'b1);
    repeat (150) cyc(1'b1, 4'($urandom));
    // halt in slot 1 of a full group, then ignored traffic
    rand_slots(4'b1111);
    make_halt(1, 2);
    commit(1'b1);
    repeat (5) cyc(1'b1, 4'b1111);
    // reset mid-operation
    cyc(1'b0, 4'b1111);
    repeat (3) cyc(1'b1, 4'b1111);
    cyc(1'b0, 4'b1111);
    // order wrap: 255 retirements then 2 more
    repeat (63) cyc(1'b1, 4'b1111);
    cyc(1'b1, 4'b0111);
    cyc(1'b1, 4'b1001);
    // random traffic with occasional halts of every kind, recovering by reset
    for (int n = 0; n < 400; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        cyc(1'b0, 4'($urandom));
      end else begin
        rand_slots(4'($urandom));
        if ($urandom_range(0, 9) == 0) make_halt($urandom_range(0, CWID - 1), $urandom_range(0, 3));
        commit(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      end
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 384'(expq.size()), 384'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_packer.md
# rvfi_commit_packer

Sits between the ROB retire port and the 8-channel RVFI monitor interface. Each cycle it takes up to COMMIT_WIDTH retiring instructions (arbitrary, possibly non-contiguous valid mask), compacts them onto the lowest-numbered RVFI channels in program order, and stamps each with a monotonically increasing `order`. After the first halt-class instruction it latches a sticky halt and suppresses all later retirements. Outputs are fully registered, so the monitor sees clean, X-free channel data one cycle after retire.

## Interface
- `COMMIT_WIDTH`, 4: ROB retire slots per cycle; legal range 1..8.
- `ORDER_W`, 64: width of the `order` field.
- `NCH`, 8: RVFI channel count; fixed at 8.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk`.
- `ret_valid`  in  COMMIT_WIDTH  per-slot retire valid; slot 0 is oldest.
- `ret_inst`  in  COMMIT_WIDTH×32  instruction word.
- `ret_pc_rdata`, `ret_pc_wdata`  in  COMMIT_WIDTH×32 each  PC of the instruction, next PC.
- `ret_rs1_addr`, `ret_rs2_addr`, `ret_rd_addr`  in  COMMIT_WIDTH×5 each  architectural register indices.
- `ret_rs1_rdata`, `ret_rs2_rdata`, `ret_rd_wdata`  in  COMMIT_WIDTH×32 each  operand and result data.
- `ret_mem_addr`, `ret_mem_rdata`, `ret_mem_wdata`  in  COMMIT_WIDTH×32 each  memory address and data.
- `ret_mem_rmask`, `ret_mem_wmask`  in  COMMIT_WIDTH×4 each  byte masks.
- `rvfi_valid`  out  NCH  channel valid.
- `rvfi_order`  out  NCH×ORDER_W  retire sequence number.
- `rvfi_*` payloads  out  NCH× the matching input width  (`inst`, `pc_rdata`, `pc_wdata`, `rs1/rs2/rd_addr`, `rs1/rs2_rdata`, `rd_wdata`, `mem_addr`, `mem_rmask`, `mem_wmask`, `mem_rdata`, `mem_wdata`).
- `halted`  out  1  sticky; set after a halt-class instruction has been emitted.
- `retired_count`  out  ORDER_W  total instructions emitted since reset; equals the next order value.

## Operation
- **Halt-class instruction:** a slot for which `pc_rdata == pc_wdata`, or `inst` equals 0x00000063, 0x0000006F or 0xF0002013.
- **Eligible slots:**
  - Slot i is eligible if `ret_valid[i]` is set and `halted` is 0.
  - Slot i is also ineligible if any lower eligible slot j < i in the same cycle is halt-class.
  - The halt-class slot itself is eligible.
- **Compaction:**
  - Let k be the number of eligible slots. The r-th eligible slot in ascending slot order (r = 0..k-1) drives channel r.
  - Channels k..NCH-1 have valid 0.
- **Order stamping:**
  - Channel r gets `order = base + r`.
  - `base` is an internal ORDER_W counter that advances by k each cycle.
  - Arithmetic is modulo 2^ORDER_W.
  - `retired_count` mirrors `base`.
- **Scrubbing, applied on the registered output:**
  - `rd_wdata` is forced to 0 when `rd_addr == 0`.
  - `rs1_rdata` and `rs2_rdata` are forced to 0 when the corresponding address is 0.
  - Every payload field of a channel with valid 0 is driven 0, never X.
- **Halt latch:**
  - `halted` is set the cycle the halt-class instruction appears on the outputs.
  - Once set, all subsequent `ret_valid` are ignored, `base` freezes, and `rvfi_valid` stays 0 until reset.
- **No backpressure:** the ROB never stalls on this block. Every eligible slot is emitted.

## Timing
- **Latency:** exactly 1 cycle from `ret_*` sampled at edge N to `rvfi_*` valid after edge N. `halted` rises on that same edge.
- **Reset values:** `rvfi_valid`, all `rvfi_*` payloads and orders, `halted`, `retired_count` and `base` are all 0.
- **Reset mid-stream:** retirements presented in a cycle with `rst`=0 are discarded. The cycle after reset deasserts, outputs are 0 and order restarts at 0.
- **First cycle after reset:** a retirement presented then appears after the next edge with order 0.
- **All slots invalid:** `rvfi_valid` is 0 and `base` is unchanged.
- **Wrap-around:** `base` at 2^ORDER_W−1 with k=2 yields orders 2^ORDER_W−1 and 0.
- **COMMIT_WIDTH < NCH:** the upper channels are permanently 0.

## Test plan
- **Basic compaction:** reset, then `ret_valid`=4'b1010 with PCs 0x100/0x104 in slots 1/3 → next cycle `rvfi_valid`=8'h03, ch0 pc 0x100 order 0, ch1 pc 0x104 order 1, `retired_count`=2.
- **Full-width back-to-back:** 4'b1111 for 3 consecutive cycles → orders 0–3, 4–7, 8–11 on ch0–3 in consecutive cycles, with no gaps or repeats.
- **Scrub:** a slot with `rd_addr`=0, `rd_wdata`=0xDEADBEEF and `rs1_addr`=0 → output `rd_wdata`=0 and `rs1_rdata`=0. Invalid channels read all-zero.
- **Halt mid-group:** slot 1 has `inst`=0x0000006F and 4'b1111 valid → ch0/ch1 valid (orders n, n+1) and `halted`=1. Slots 2–3 dropped. All following retirements produce `rvfi_valid`=0 and `retired_count` stays n+2.
- **Reset mid-operation:** after 10 retirements, drive `rst`=0 for one cycle with 4'b1111 valid → outputs 0 during and after the reset edge. The next retirement gets order 0 and `halted` is cleared.
- **Order wrap:** preload `base` to 2^ORDER_W−1 via a bench-forced value or ORDER_W=4 with 15 retirements, then 2 retirements → orders 15 and 0.
